// File: rtl/dragonfang_pkg.sv
// Dragonfang core-wide types: result tag width and the tagged result packet.
package dragonfang_pkg;

    localparam int unsigned TAG_WIDTH = 5;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]          tag;
        logic [riscv_v_pkg::VLEN-1:0]  data;
    } data_packet_t;

endpackage : dragonfang_pkg

// File: rtl/riscv_v_pkg.sv
// Vector-extension architectural constants shared across the Dragonfang vector pipeline.
package riscv_v_pkg;

    localparam int unsigned VLEN = 128;

endpackage : riscv_v_pkg

// File: rtl/writeback_unit.sv
// Vector writeback unit: buffers tagged execution results in a circular FIFO, retires them
// in order to the register file and feeds the last retired result back as a bypass.
module writeback_unit
    import dragonfang_pkg::*;
    import riscv_v_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         input_valid,
    input  data_packet_t                 input_port,
    output logic                         input_ready,
    output logic                         write_enable,
    input  logic                         write_ready,
    output logic [TAG_WIDTH-1:0]         write_address,
    output logic [VLEN-1:0]              write_data,
    output logic                         bypass_valid,
    output data_packet_t                 bypass_port,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [15:0]                  retire_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    data_packet_t       mem [DEPTH];
    data_packet_t       head;
    logic               push;
    logic               pop;

    // Pointers wrap explicitly so non-power-of-two depths never index past DEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign input_ready  = (state != ST_FULL);
    assign write_enable = (state != ST_EMPTY);
    assign push         = input_valid && input_ready && !flush;
    assign pop          = write_enable && write_ready && !flush;

    assign head          = mem[rd_ptr];
    assign write_address = head.tag;
    assign write_data    = head.data;
    assign occupancy     = count;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (push) state_next = ST_PARTIAL;
                end
                ST_PARTIAL: begin
                    if (push && !pop && count == CNT_W'(DEPTH - 1)) begin
                        state_next = ST_FULL;
                    end else if (pop && !push && count == CNT_W'(1)) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) state_next = ST_PARTIAL;
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after a push has written it.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= input_port;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bypass_valid <= 1'b0;
            bypass_port  <= '0;
            retire_count <= '0;
        end else if (flush) begin
            bypass_valid <= 1'b0;
        end else if (pop) begin
            bypass_valid <= 1'b1;
            bypass_port  <= head;
            if (retire_count != 16'hFFFF) begin
                retire_count <= retire_count + 16'd1;
            end
        end
    end

endmodule : writeback_unit

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_writeback_unit;
    import dragonfang_pkg::*;
    import riscv_v_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                  clock;
    logic                  reset_n;
    logic                  flush;
    logic                  input_valid;
    data_packet_t          input_port;
    logic                  input_ready;
    logic                  write_enable;
    logic                  write_ready;
    logic [TAG_WIDTH-1:0]  write_address;
    logic [VLEN-1:0]       write_data;
    logic                  bypass_valid;
    data_packet_t          bypass_port;
    logic [CNT_W-1:0]      occupancy;
    logic [15:0]           retire_count;

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .input_valid  (input_valid),
        .input_port   (input_port),
        .input_ready  (input_ready),
        .write_enable (write_enable),
        .write_ready  (write_ready),
        .write_address(write_address),
        .write_data   (write_data),
        .bypass_valid (bypass_valid),
        .bypass_port  (bypass_port),
        .occupancy    (occupancy),
        .retire_count (retire_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: an in-order queue of results plus the retire side effects.
    data_packet_t          m_q[$];
    data_packet_t          m_bp;
    logic                  m_bv;
    logic [15:0]           m_retire;
    bit                    m_pushed;
    logic [TAG_WIDTH-1:0]  dut_log[$];

    function automatic logic [VLEN-1:0] rand_data();
        logic [VLEN-1:0] d;
        for (int i = 0; i < VLEN / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic data_packet_t rand_pkt(input int tag);
        data_packet_t p;
        p.tag  = TAG_WIDTH'(tag);
        p.data = rand_data();
        return p;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_bp     = '0;
        m_bv     = 1'b0;
        m_retire = '0;
    endtask

    // Advance one clock: inputs are stable now, outputs are sampled 1ns after the edge.
    task automatic cycle();
        bit push, pop;
        push = input_valid && (m_q.size() != DEPTH) && !flush;
        pop  = (m_q.size() != 0) && write_ready && !flush;
        if (write_enable && write_ready && !flush) dut_log.push_back(write_address);
        @(posedge clock);
        #1;
        m_pushed = push;
        if (flush) begin
            m_q.delete();
            m_bv = 1'b0;
        end else begin
            if (pop) begin
                m_bp = m_q.pop_front();
                m_bv = 1'b1;
                if (m_retire != 16'hFFFF) m_retire = m_retire + 16'd1;
            end
            if (push) m_q.push_back(input_port);
        end
    endtask

    task automatic idle_inputs();
        input_valid = 1'b0;
        write_ready = 1'b0;
        flush       = 1'b0;
        input_port  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL reset_input_ready: got %b expected 1", input_ready); end
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_write_enable: got %b expected 0", write_enable); end
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        checks++; if (bypass_valid !== 1'b0) begin errors++; $display("FAIL reset_bypass_valid: got %b expected 0", bypass_valid); end
        checks++; if (bypass_port !== '0) begin errors++; $display("FAIL reset_bypass_port: got %h expected 0", bypass_port); end
        checks++; if (retire_count !== 16'd0) begin errors++; $display("FAIL reset_retire_count: got %0d expected 0", retire_count); end
    endtask

    // Runs straight after reset release, so the push lands on the first edge.
    task automatic test_single();
        data_packet_t p;
        p = rand_pkt(5);
        input_port  = p;
        input_valid = 1'b1;
        write_ready = 1'b1;
        cycle();
        input_valid = 1'b0;
        checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL single_write_enable: got %b expected 1", write_enable); end
        checks++; if (write_address !== 5'd5) begin errors++; $display("FAIL single_write_address: got %0d expected 5", write_address); end
        checks++; if (write_data !== p.data) begin errors++; $display("FAIL single_write_data: got %h expected %h", write_data, p.data); end
        cycle();
        checks++; if (bypass_port !== p) begin errors++; $display("FAIL single_bypass_port: got %h expected %h", bypass_port, p); end
        checks++; if (bypass_valid !== 1'b1) begin errors++; $display("FAIL single_bypass_valid: got %b expected 1", bypass_valid); end
        checks++; if (retire_count !== 16'd1) begin errors++; $display("FAIL single_retire_count: got %0d expected 1", retire_count); end
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL single_occupancy: got %0d expected 0", occupancy); end
        write_ready = 1'b0;
    endtask

    task automatic test_fill_stall();
        data_packet_t pushed[DEPTH];
        write_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pushed[i]   = rand_pkt(10 + i);
            input_port  = pushed[i];
            input_valid = 1'b1;
            cycle();
        end
        checks++; if (occupancy !== CNT_W'(DEPTH)) begin errors++; $display("FAIL fill_occupancy: got %0d expected %0d", occupancy, DEPTH); end
        checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL fill_input_ready: got %b expected 0", input_ready); end
        input_port = rand_pkt(30);
        cycle();
        checks++; if (occupancy !== CNT_W'(DEPTH)) begin errors++; $display("FAIL fill_fifth_rejected: got %0d expected %0d", occupancy, DEPTH); end
        input_valid = 1'b0;
        write_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (write_address !== pushed[i].tag || write_data !== pushed[i].data) begin
                errors++; $display("FAIL fill_retire_order[%0d]: got tag %0d expected %0d", i, write_address, pushed[i].tag);
            end
            cycle();
            checks++; if (occupancy !== CNT_W'(DEPTH - 1 - i)) begin errors++; $display("FAIL fill_drain_occupancy[%0d]: got %0d expected %0d", i, occupancy, DEPTH - 1 - i); end
        end
        write_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        write_ready = 1'b0;
        input_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            input_port = rand_pkt(i);
            cycle();
        end
        write_ready = 1'b1;
        input_port  = rand_pkt(20);
        checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL fullpp_ready_before: got %b expected 0", input_ready); end
        cycle();
        checks++; if (occupancy !== CNT_W'(DEPTH - 1)) begin errors++; $display("FAIL fullpp_occupancy_1: got %0d expected %0d", occupancy, DEPTH - 1); end
        checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL fullpp_ready_after: got %b expected 1", input_ready); end
        cycle();
        checks++; if (occupancy !== CNT_W'(DEPTH - 1)) begin errors++; $display("FAIL fullpp_occupancy_2: got %0d expected %0d", occupancy, DEPTH - 1); end
        checks++; if (m_q.size() != 0 && write_address !== m_q[0].tag) begin errors++; $display("FAIL fullpp_head: got %0d expected %0d", write_address, m_q[0].tag); end
        input_valid = 1'b0;
        repeat (DEPTH) cycle();
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL fullpp_drained: got %0d expected 0", occupancy); end
        write_ready = 1'b0;
    endtask

    task automatic test_wrap_around();
        int idx = 0;
        int c = 0;
        dut_log.delete();
        while (c < 200 && !(idx == 10 && m_q.size() == 0)) begin
            input_valid = (idx < 10);
            input_port  = rand_pkt(idx);
            write_ready = c[0];
            cycle();
            if (m_pushed) idx++;
            checks++; if (occupancy !== CNT_W'(m_q.size())) begin errors++; $display("FAIL wrap_occupancy: got %0d expected %0d", occupancy, m_q.size()); end
            c++;
        end
        input_valid = 1'b0;
        write_ready = 1'b0;
        checks++; if (idx != 10 || m_q.size() != 0) begin errors++; $display("FAIL wrap_timeout: pushed %0d expected 10", idx); end
        checks++; if (dut_log.size() != 10) begin errors++; $display("FAIL wrap_write_count: got %0d expected 10", dut_log.size()); end
        for (int i = 0; i < 10 && i < dut_log.size(); i++) begin
            checks++; if (dut_log[i] !== TAG_WIDTH'(i)) begin errors++; $display("FAIL wrap_order[%0d]: got %0d expected %0d", i, dut_log[i], i); end
        end
    endtask

    task automatic test_flush();
        logic [15:0] retire_before;
        write_ready = 1'b0;
        input_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            input_port = rand_pkt(i + 3);
            cycle();
        end
        input_valid = 1'b0;
        write_ready = 1'b1;
        cycle();
        checks++; if (occupancy !== CNT_W'(3) || bypass_valid !== 1'b1) begin errors++; $display("FAIL flush_setup: occupancy %0d bypass_valid %b expected 3 and 1", occupancy, bypass_valid); end
        retire_before = m_retire;
        input_valid = 1'b1;
        input_port  = rand_pkt(9);
        flush       = 1'b1;
        cycle();
        flush       = 1'b0;
        input_valid = 1'b0;
        write_ready = 1'b0;
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL flush_occupancy: got %0d expected 0", occupancy); end
        checks++; if (bypass_valid !== 1'b0) begin errors++; $display("FAIL flush_bypass_valid: got %b expected 0", bypass_valid); end
        checks++; if (retire_count !== retire_before) begin errors++; $display("FAIL flush_retire_count: got %0d expected %0d", retire_count, retire_before); end
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL flush_write_enable: got %b expected 0", write_enable); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            input_valid = ($urandom_range(0, 3) != 0);
            write_ready = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            input_port  = rand_pkt($urandom_range(0, 31));
            cycle();
            checks++; if (occupancy !== CNT_W'(m_q.size())) begin errors++; $display("FAIL rand_occupancy@%0d: got %0d expected %0d", c, occupancy, m_q.size()); end
            checks++; if (input_ready !== (m_q.size() != DEPTH)) begin errors++; $display("FAIL rand_input_ready@%0d: got %b", c, input_ready); end
            checks++; if (write_enable !== (m_q.size() != 0)) begin errors++; $display("FAIL rand_write_enable@%0d: got %b", c, write_enable); end
            checks++; if (bypass_valid !== m_bv) begin errors++; $display("FAIL rand_bypass_valid@%0d: got %b expected %b", c, bypass_valid, m_bv); end
            checks++; if (retire_count !== m_retire) begin errors++; $display("FAIL rand_retire_count@%0d: got %0d expected %0d", c, retire_count, m_retire); end
            if (m_q.size() != 0) begin
                checks++; if (write_address !== m_q[0].tag || write_data !== m_q[0].data) begin errors++; $display("FAIL rand_head@%0d: got tag %0d expected %0d", c, write_address, m_q[0].tag); end
            end
            if (m_bv) begin
                checks++; if (bypass_port !== m_bp) begin errors++; $display("FAIL rand_bypass_port@%0d: got %h expected %h", c, bypass_port, m_bp); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        write_ready = 1'b0;
        input_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            input_port = rand_pkt(i + 1);
            cycle();
        end
        write_ready = 1'b1;
        input_valid = 1'b0;
        cycle();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL midreset_occupancy: got %0d expected 0", occupancy); end
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL midreset_write_enable: got %b expected 0", write_enable); end
        checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL midreset_input_ready: got %b expected 1", input_ready); end
        checks++; if (bypass_valid !== 1'b0 || bypass_port !== '0) begin errors++; $display("FAIL midreset_bypass: valid %b port %h expected 0", bypass_valid, bypass_port); end
        checks++; if (retire_count !== 16'd0) begin errors++; $display("FAIL midreset_retire_count: got %0d expected 0", retire_count); end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cycle();
        checks++; if (occupancy !== '0 || retire_count !== 16'd0) begin errors++; $display("FAIL midreset_no_write: occupancy %0d retire %0d expected 0", occupancy, retire_count); end
        write_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_full_push_pop();
        test_wrap_around();
        test_flush();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_writeback_unit

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The module SHALL import dragonfang_pkg and riscv_v_pkg; data width is VLEN, and tag width is TAG_WIDTH (5, vector register index) from the packages.
REQ-002 Parameter: DEPTH, default 4, number of result buffer entries (legal range 2..16, not restricted to powers of two).
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous discard of all buffered results.
REQ-006 input_valid  input  1  the execution stage presents a result.
REQ-007 input_port  input  data_packet_t (TAG_WIDTH+VLEN)  result tag (destination vd) plus data, from the execution stage.
REQ-008 input_ready  output  1  a buffer entry is free.
REQ-009 write_enable  output  1  a register-file write request is pending.
REQ-010 write_ready  input  1  the register file accepts the write this cycle.
REQ-011 write_address  output  TAG_WIDTH  destination vector register.
REQ-012 write_data  output  VLEN  write data.
REQ-013 bypass_valid  output  1  bypass_port holds a retired result.
REQ-014 bypass_port  output  data_packet_t  last retired result, fed back to the execution-stage bypass input.
REQ-015 occupancy  output  $clog2(DEPTH+1)  number of valid entries.
REQ-016 retire_count  output  16  number of retired writes; saturates at 16'hFFFF.

Function
REQ-017 Buffer organisation:
- circular FIFO of DEPTH entries;
- write pointer, read pointer and count are registered;
- each pointer wraps from DEPTH-1 to 0 explicitly.
REQ-018 Push (accept) occurs when input_valid && input_ready && !flush.
- The tag and data are stored at the write pointer.
- The write pointer then advances.
REQ-019 input_ready = (count != DEPTH). It depends on registered state only, never combinationally on write_ready.
REQ-020 Pop (retire) occurs when write_enable && write_ready && !flush.
- The read pointer advances.
- retire_count increments.
REQ-021 Write port outputs:
- write_enable = (count != 0);
- write_address and write_data show the head entry, combinationally from the registered array.
REQ-022 Latency: a result accepted into an empty buffer at edge N appears on the write port in cycle N+1. There is no same-cycle pass-through.
REQ-023 Push and pop in the same cycle leave count unchanged and advance both pointers.
REQ-024 Full buffer: input_ready=0, even when a pop occurs in the same cycle. The freed entry becomes visible as input_ready=1 in the next cycle.
REQ-025 Empty buffer: write_enable=0; write_ready is ignored.
REQ-026 Control states are derived from count:
- EMPTY (0);
- PARTIAL (1..DEPTH-1);
- FULL (DEPTH).
REQ-027 State transitions:
- EMPTY->PARTIAL on push;
- PARTIAL->FULL on push without pop when count=DEPTH-1;
- FULL->PARTIAL on pop;
- PARTIAL->EMPTY on pop without push when count=1;
- any state->EMPTY on flush.
REQ-028 On each retire, at the clock edge, bypass_port <= {head tag, head data} and bypass_valid <= 1. Both hold until the next retire, flush, or reset.
REQ-029 flush takes priority over a simultaneous push and pop:
- pointers and count clear to 0;
- bypass_valid clears to 0;
- no retire is counted;
- retire_count is kept.
REQ-030 retire_count saturates at 16'hFFFF; further retires leave it unchanged.
REQ-031 occupancy equals count at all times.

Reset
REQ-032 On reset_n low, the following SHALL clear asynchronously: pointers=0, count=0, bypass_valid=0, bypass_port=0, retire_count=0.
- Consequent outputs: input_ready=1, write_enable=0, occupancy=0.
REQ-033 Buffer data storage need not be reset.
REQ-034 Reset asserted mid-operation discards all pending entries with no partial write.
REQ-035 The first push is accepted on the first rising edge after reset_n deasserts.

Verification
REQ-036 Single result:
- Stimulus: push tag=5, data=A with write_ready=1.
- Response: next cycle write_enable=1, address=5, data=A.
- The following cycle: bypass_port={5,A}, bypass_valid=1, retire_count=1, occupancy=0.
REQ-037 Fill and stall:
- Stimulus: write_ready=0; push 4 results (DEPTH=4).
- Response: occupancy=4, input_ready=0; a 5th input_valid is not accepted.
- Then write_ready=1: results retire in order, one per cycle.
REQ-038 Full with simultaneous push and pop:
- Stimulus: buffer full, write_ready=1, input_valid=1.
- Response: no push that cycle, occupancy=3; push accepted next cycle, occupancy stays 3.
REQ-039 Wrap-around:
- Stimulus: 10 results with tags 0..9, write_ready toggled every cycle.
- Response: write order 0..9 exactly; no loss or duplication.
REQ-040 Flush:
- Stimulus: occupancy=3; flush asserted in the same cycle as a push and a pop.
- Response: occupancy=0, bypass_valid=0, retire_count unchanged.
- Reset mid-operation: asynchronous clear of the same state, checked before the next clock edge.
